spi_flash_jpeg_reader: RTL and testbench
========================================

Name: spi_flash_jpeg_reader

Overview:
- Streams stored JPEG images byte-by-byte out of a W25Q32JV-class SPI NOR flash to a downstream JPEG decoder.
- Keeps a current image index; image n starts at byte address START_ADDR + n*ADDR_OFFSET.
- Issues a Fast Read Dual Output (0x3B) and delivers data bytes on a ready/enable handshake.
- Sits between the flash pins and the decoder. Pushbutton next/back selects the image; the decoder stops the stream with interrupt or flush.

Parameters:
SCLK_FREQ, 6'd1, half-period of o_sclk in i_sysclk cycles (0 treated as 1)
ADDR_WIDTH, 24, flash byte-address width
NUM_OF_JPG, 16, number of stored images, index range 0..NUM_OF_JPG-1
START_ADDR, 'h00000, byte address of image 0
ADDR_OFFSET, 'h00200, byte stride between consecutive images

Ports:
i_sysclk  in  1  system clock, all logic on rising edge
i_arst  in  1  reset, synchronous, active-low (0 = reset)
i_next  in  1  one-cycle pulse: select next image
i_back  in  1  one-cycle pulse: select previous image
i_interrupt  in  1  pulse: end current read (decoder finished)
i_flush  in  1  pulse: abort and restart current image from its start
i_miso  in  1  flash DO / IO1
i_miso_1  in  1  flash DIO / IO0 (input during dual data phase)
o_nss  out  1  flash chip select, active-low
o_sclk  out  1  SPI clock, mode 0 (idle low)
o_mosi  out  1  serial data to flash DIO
o_mosi_oe  out  1  drive enable for DIO pad
i_ready  in  1  downstream can accept a byte
o_byte_en  out  1  one-cycle strobe, o_byte valid
o_byte  out  8  data byte

Behaviour:
- Reset values: o_nss=1, o_sclk=0, o_mosi=0, o_mosi_oe=0, o_byte_en=0, o_byte=0, index=0. State is IDLE.
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> STOP -> (WAIT | CMD).
- IDLE: one cycle after reset release, go to CMD using the current index.
- CMD: o_nss low, o_mosi_oe=1. Shift 8'h3B MSB first.
- ADDR: shift the 24-bit address MSB first. The address is computed in ADDR_WIDTH bits; overflow wraps.
- DUMMY: 8 clocks with o_mosi_oe=0.
- DATA: 4 clocks per byte, o_mosi_oe=0.
  - Each clock samples i_miso into odd bits (7,5,3,1) and i_miso_1 into even bits (6,4,2,0).
  - After the 4th rising edge, o_byte is loaded and o_byte_en pulses for exactly one cycle.
- SPI timing:
  - o_sclk toggles every SCLK_FREQ cycles.
  - Outputs change while o_sclk is low.
  - Inputs are sampled in the cycle o_sclk rises.
  - With SCLK_FREQ=1, one sclk period is 2 sysclk cycles.
- Flow control: a byte is only started when i_ready=1. If i_ready=0 at a byte boundary, o_sclk holds low and o_nss stays low. The stream resumes seamlessly with no lost or repeated byte.
- i_interrupt in CMD..DATA: finish nothing further, drive o_sclk low, raise o_nss, enter WAIT. No o_byte_en occurs after the cycle following i_interrupt.
- WAIT: idle until next/back/flush.
- i_next (any state): index = index+1, wrapping NUM_OF_JPG-1 -> 0. Abort any transfer (STOP), then start CMD at the new address.
- i_back: index = index-1, wrapping 0 -> NUM_OF_JPG-1. Same restart as i_next.
- i_flush: index unchanged; abort and restart CMD at the current image start.
- Simultaneous events: i_next and i_back together are ignored. Either one together with i_flush or i_interrupt takes priority. i_flush beats i_interrupt.
- STOP: o_nss high for at least 2 sclk periods (4*SCLK_FREQ cycles) before the next CMD.
- Reset asserted mid-transfer: all outputs return to reset values on the next clock edge and index returns to 0.

Decomposition:
- Package spi_flash_pkg: opcode constant 8'h3B, dummy-clock count 8, state enum, bit-count constants (8, 24).
- One natural sub-module, spi_flash_shifter: sclk divider, shift-out/shift-in engine with single/dual mode select, pause-on-boundary, abort.
- The top holds the FSM, index counter and address multiply/add.

Test Plan:
- Release reset with a flash model at 0x000000 = 0xFF,0xD8,0xFF,0xE0 -> o_nss falls; o_mosi sends 0x3B then 0x000000 (32 clocks); 8 dummy clocks; o_byte_en strobes FF,D8,FF,E0; 4 sclk per byte.
- Pulse i_next -> o_nss high ≥4 cycles, then read at 0x000200. Pulse i_back twice -> 0x000000, then 0x001E00 (index 15 wrap).
- Hold i_ready=0 for 50 cycles mid-stream -> no o_byte_en, o_sclk low, o_nss low. Resumed bytes continue the address sequence exactly.
- Pulse i_interrupt during DATA -> o_nss=1 within 1 sclk period, no further strobes. Later i_flush -> read restarts at the current image start.
- Assert i_next and i_back in the same cycle during WAIT -> no transaction. Assert reset mid-ADDR -> o_nss=1, o_sclk=0 next edge; after release a read at 0x000000 starts.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash JPEG reader.
//   OPC_READ_DUAL : Fast Read Dual Output opcode
//   *_CLKS        : sclk counts of each transaction phase
//   state_e       : top-level transaction FSM states
package spi_flash_pkg;
  localparam logic [7:0] OPC_READ_DUAL = 8'h3B;
  localparam int         CMD_BITS      = 8;
  localparam int         ADDR_BITS     = 24;
  localparam logic [5:0] CMD_CLKS      = 6'(CMD_BITS);
  localparam logic [5:0] ADDR_CLKS     = 6'(ADDR_BITS);
  localparam logic [5:0] DUMMY_CLKS    = 6'd8;
  // dual output: two bits per clock, four clocks per byte
  localparam logic [5:0] DATA_CLKS     = 6'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_STOP, ST_WAIT
  } state_e;
endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 bit engine. Runs one burst of nclk_i sclk periods per start_i.
//   clk_i/rst_ni : clock, synchronous active-low reset
//   start_i      : begin a burst (honoured only while idle)
//   dual_i       : burst samples miso_i/miso1_i into rx (2 bits/clock)
//   abort_i      : stop at once, sclk forced low
//   nclk_i/tx_i  : burst length, left-aligned shift-out data (MSB first)
//   sclk_o/mosi_o: pins; busy_o while bursting; done_o one cycle after a burst
//   rx_done_o/rx_o : pulse when a dual burst's last sample lands in rx_o
module spi_flash_shifter #(
  parameter int SCLK_FREQ = 1
)(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        dual_i,
  input  logic        abort_i,
  input  logic [5:0]  nclk_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  input  logic        miso1_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        rx_done_o,
  output logic [7:0]  rx_o
);
  localparam int HALF = (SCLK_FREQ < 1) ? 1 : SCLK_FREQ;
  localparam int DW   = $clog2(HALF + 1);

  logic          active_q, active_d, sclk_q, sclk_d, dual_q, dual_d;
  logic          done_q, done_d, rx_done_q, rx_done_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;

  always_comb begin
    active_d = active_q; sclk_d = sclk_q; dual_d = dual_q; div_d = div_q;
    cnt_d = cnt_q; tx_d = tx_q; rx_d = rx_q; done_d = 1'b0; rx_done_d = 1'b0;
    if (abort_i) begin
      active_d = 1'b0; sclk_d = 1'b0; div_d = '0; tx_d = '0;
    end else if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1; div_d = '0; cnt_d = nclk_i; tx_d = tx_i; dual_d = dual_i;
      end
    end else if (div_q != DW'(HALF - 1)) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      if (!sclk_q) begin
        // rising edge: sample in the same cycle sclk goes high
        sclk_d = 1'b1;
        cnt_d  = cnt_q - 6'd1;
        if (dual_q) begin
          rx_d      = {rx_q[5:0], miso_i, miso1_i};
          rx_done_d = (cnt_q == 6'd1);
        end
      end else begin
        // falling edge: present next bit while sclk is low
        sclk_d = 1'b0;
        tx_d   = {tx_q[30:0], 1'b0};
        if (cnt_q == 6'd0) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0; sclk_q <= 1'b0; dual_q <= 1'b0; div_q <= '0;
      cnt_q <= '0; tx_q <= '0; rx_q <= '0; done_q <= 1'b0; rx_done_q <= 1'b0;
    end else begin
      active_q <= active_d; sclk_q <= sclk_d; dual_q <= dual_d; div_q <= div_d;
      cnt_q <= cnt_d; tx_q <= tx_d; rx_q <= rx_d; done_q <= done_d; rx_done_q <= rx_done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[31];
  assign busy_o    = active_q;
  assign done_o    = done_q;
  assign rx_done_o = rx_done_q;
  assign rx_o      = rx_q;
endmodule

// File: rtl/spi_flash_jpeg_reader.sv
// Streams JPEG images out of a SPI NOR flash with Fast Read Dual Output.
// Image n lives at START_ADDR + n*ADDR_OFFSET; next/back step the index,
// flush restarts the current image, interrupt parks the reader in WAIT.
//   i_sysclk/i_arst : clock, synchronous active-low reset
//   i_next/i_back/i_interrupt/i_flush : control pulses
//   i_miso/i_miso_1 : flash IO1/IO0 ; o_nss/o_sclk/o_mosi/o_mosi_oe : flash pins
//   i_ready/o_byte_en/o_byte : downstream byte handshake
module spi_flash_jpeg_reader #(
  parameter logic [5:0]            SCLK_FREQ   = 6'd1,
  parameter int                    ADDR_WIDTH  = 24,
  parameter int                    NUM_OF_JPG  = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 'h00000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET = 'h00200
)(
  input  logic       i_sysclk,
  input  logic       i_arst,
  input  logic       i_next,
  input  logic       i_back,
  input  logic       i_interrupt,
  input  logic       i_flush,
  input  logic       i_miso,
  input  logic       i_miso_1,
  output logic       o_nss,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_mosi_oe,
  input  logic       i_ready,
  output logic       o_byte_en,
  output logic [7:0] o_byte
);
  import spi_flash_pkg::*;

  localparam int         HALF  = (SCLK_FREQ == 6'd0) ? 1 : int'(SCLK_FREQ);
  localparam int         IDX_W = (NUM_OF_JPG > 1) ? $clog2(NUM_OF_JPG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_JPG - 1);
  // nss stays high for two sclk periods between transactions
  localparam logic [8:0] STOP_LAST = 9'(4 * HALF - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [8:0]       stop_cnt_q, stop_cnt_d;
  logic             nss_q, nss_d, oe_q, oe_d, byte_en_q, byte_en_d;
  logic [7:0]       byte_q, byte_d;

  logic                  sh_start, sh_dual, sh_abort, sh_busy, sh_done, sh_rx_done;
  logic [5:0]            sh_nclk;
  logic [31:0]           sh_tx;
  logic [7:0]            sh_rx;
  logic                  xfer, nav;
  logic [ADDR_WIDTH-1:0] addr_full;
  logic [ADDR_BITS-1:0]  addr_tx;

  assign addr_full = START_ADDR + ADDR_WIDTH'(idx_q) * ADDR_OFFSET;
  assign addr_tx   = ADDR_BITS'(addr_full);
  assign xfer      = state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
  // next together with back cancels out
  assign nav       = i_next ^ i_back;

  always_comb begin
    state_d = state_q; idx_d = idx_q; byte_en_d = 1'b0; byte_d = byte_q;
    sh_abort = 1'b0; sh_dual = 1'b0; sh_nclk = CMD_CLKS; sh_tx = '0;
    case (state_q)
      ST_IDLE:  state_d = ST_CMD;
      ST_CMD: begin
        sh_tx = {OPC_READ_DUAL, 24'h0};
        if (sh_done) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        sh_nclk = ADDR_CLKS;
        sh_tx   = {addr_tx, 8'h0};
        if (sh_done) state_d = ST_DUMMY;
      end
      ST_DUMMY: begin
        sh_nclk = DUMMY_CLKS;
        if (sh_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        sh_nclk = DATA_CLKS;
        sh_dual = 1'b1;
        if (sh_rx_done) begin
          byte_en_d = 1'b1;
          byte_d    = sh_rx;
        end
      end
      ST_STOP:  if (stop_cnt_q == STOP_LAST) state_d = ST_CMD;
      default:  ;
    endcase
    // bytes only start on a boundary with the sink ready; flow control is
    // just withholding the next burst, so sclk idles low and nss stays low
    sh_start = xfer && !sh_busy && !sh_done && (state_q != ST_DATA || i_ready);

    if (nav) begin
      idx_d    = i_next ? ((idx_q == LAST_IDX) ? '0 : idx_q + 1'b1)
                        : ((idx_q == '0) ? LAST_IDX : idx_q - 1'b1);
      state_d  = ST_STOP;
      sh_abort = 1'b1;
    end else if (i_flush) begin
      state_d  = ST_STOP;
      sh_abort = 1'b1;
    end else if (i_interrupt && xfer) begin
      state_d  = ST_WAIT;
      sh_abort = 1'b1;
    end
    if (sh_abort) begin
      sh_start  = 1'b0;
      byte_en_d = 1'b0;
      byte_d    = byte_q;
    end

    stop_cnt_d = (state_q == ST_STOP && state_d == ST_STOP && !sh_abort)
                 ? stop_cnt_q + 9'd1 : 9'd0;
    nss_d = !(state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});
    oe_d  = state_d inside {ST_CMD, ST_ADDR};
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_arst) begin
      state_q <= ST_IDLE; idx_q <= '0; stop_cnt_q <= '0;
      nss_q <= 1'b1; oe_q <= 1'b0; byte_en_q <= 1'b0; byte_q <= '0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; stop_cnt_q <= stop_cnt_d;
      nss_q <= nss_d; oe_q <= oe_d; byte_en_q <= byte_en_d; byte_q <= byte_d;
    end
  end

  spi_flash_shifter #(.SCLK_FREQ(HALF)) u_shifter (
    .clk_i     (i_sysclk),
    .rst_ni    (i_arst),
    .start_i   (sh_start),
    .dual_i    (sh_dual),
    .abort_i   (sh_abort),
    .nclk_i    (sh_nclk),
    .tx_i      (sh_tx),
    .miso_i    (i_miso),
    .miso1_i   (i_miso_1),
    .sclk_o    (o_sclk),
    .mosi_o    (o_mosi),
    .busy_o    (sh_busy),
    .done_o    (sh_done),
    .rx_done_o (sh_rx_done),
    .rx_o      (sh_rx)
  );

  assign o_nss     = nss_q;
  assign o_mosi_oe = oe_q;
  assign o_byte_en = byte_en_q;
  assign o_byte    = byte_q;
endmodule

// File: tb/tb_spi_flash_jpeg_reader.sv
module tb_spi_flash_jpeg_reader;
  localparam int H = 2, N = 16, START = 0, OFF = 'h200;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_next = 0, i_back = 0, i_interrupt = 0, i_flush = 0;
  logic miso = 0, miso1 = 0, ready = 1;
  logic o_nss, o_sclk, o_mosi, o_mosi_oe, o_byte_en;
  logic [7:0] o_byte;

  always #5 clk = ~clk;

  spi_flash_jpeg_reader #(
    .SCLK_FREQ(6'(H)), .ADDR_WIDTH(24), .NUM_OF_JPG(N),
    .START_ADDR(24'(START)), .ADDR_OFFSET(24'(OFF))
  ) dut (
    .i_sysclk(clk), .i_arst(rst_n), .i_next(i_next), .i_back(i_back),
    .i_interrupt(i_interrupt), .i_flush(i_flush), .i_miso(miso), .i_miso_1(miso1),
    .o_nss(o_nss), .o_sclk(o_sclk), .o_mosi(o_mosi), .o_mosi_oe(o_mosi_oe),
    .i_ready(ready), .o_byte_en(o_byte_en), .o_byte(o_byte)
  );

  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned seed;
  int          exp_idx = 0;
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'd0:   return 8'hFF;
      24'd1:   return 8'hD8;
      24'd2:   return 8'hFF;
      24'd3:   return 8'hE0;
      default: return 8'(a * 37 + (a >> 7) + seed);
    endcase
  endfunction
  function automatic logic [23:0] exp_start();
    return 24'(START + exp_idx * OFF);
  endfunction

  // ---------------- flash model ----------------
  int          rises = 0, k;
  logic [31:0] ca;
  logic [23:0] rd_addr = '0, txn_start = '0, exp_addr = '0;
  logic [7:0]  fb;
  int          nbytes = 0, total = 0;

  always @(negedge o_nss) begin
    rises = 0; nbytes = 0;
    txn_start = exp_start();
    exp_addr  = txn_start;
  end

  always @(posedge o_sclk) if (!o_nss && rst_n) begin
    chk("mosi_oe", o_mosi_oe, rises < 32);
    if (rises < 32) ca = {ca[30:0], o_mosi};
    rises++;
    if (rises == 32) begin
      chk("opcode", ca[31:24], 8'h3B);
      chk("rd_addr", ca[23:0], txn_start);
      rd_addr = ca[23:0];
    end
  end

  // flash shifts out a bit pair on each falling sclk once 40 clocks passed
  always @(negedge o_sclk) if (!o_nss && rises >= 40) begin
    k  = rises - 40;
    fb = fbyte(rd_addr + 24'(k / 4));
    miso  = fb[7 - 2 * (k % 4)];
    miso1 = fb[6 - 2 * (k % 4)];
  end

  // ---------------- scoreboard / protocol monitor ----------------
  int hi = 0, gap = 0;
  bit gap_armed = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hi = 0; gap = 0; gap_armed = 0;
    end else begin
      if (o_byte_en) begin
        chk("byte", o_byte, fbyte(exp_addr));
        chk("clks_per_byte", rises - 40, 4 * (nbytes + 1));
        nbytes++; total++; exp_addr++;
      end
      if (o_sclk) hi++;
      else begin
        if (hi != 0 && !o_nss) chk("sclk_high", hi, H);
        hi = 0;
      end
      if (o_nss) gap++;
      else begin
        if (gap_armed && gap != 0) chk("nss_gap_ge_4h", gap >= 4 * H, 1);
        gap = 0; gap_armed = 1;
      end
    end
  end

  bit rnd_ready = 0, ready_fix = 1;
  always @(negedge clk) ready = rnd_ready ? (($urandom % 4) != 0) : ready_fix;

  // ---------------- stimulus ----------------
  task automatic wait_bytes(input int n);
    int tgt, c;
    tgt = total + n; c = 0;
    while (total < tgt && c < 3000 + 200 * n) begin @(negedge clk); c++; end
    if (total < tgt) chk("wait_bytes_timeout", total, tgt);
  endtask

  task automatic ev(input logic nx, input logic bk, input logic fl, input logic it);
    @(negedge clk);
    i_next = nx; i_back = bk; i_flush = fl; i_interrupt = it;
    if (nx ^ bk) exp_idx = nx ? (exp_idx + 1) % N : (exp_idx + N - 1) % N;
    @(negedge clk);
    i_next = 0; i_back = 0; i_flush = 0; i_interrupt = 0;
  endtask

  int cnt_a, cnt_b, cnt_c, c, sel;
  logic [3:0] combos [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b1010,
                             4'b0101, 4'b1110, 4'b0011, 4'b1001};

  initial begin
    seed = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_nss", o_nss, 1);
    chk("rst_sclk", o_sclk, 0);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_oe", o_mosi_oe, 0);
    chk("rst_byte_en", o_byte_en, 0);
    chk("rst_byte", o_byte, 0);
    rst_n = 1;

    // header read from image 0
    wait_bytes(4);
    chk("first_addr", rd_addr, 24'h000000);
    rnd_ready = 1; wait_bytes(20); rnd_ready = 0;

    ev(1, 0, 0, 0); wait_bytes(3);
    chk("next_addr", rd_addr, 24'h000200);
    ev(0, 1, 0, 0); wait_bytes(2);
    ev(0, 1, 0, 0); wait_bytes(2);
    chk("wrap_addr", rd_addr, 24'h001E00);

    // random event combos with random back-pressure
    for (int i = 0; i < 8; i++) begin
      rnd_ready = 1;
      wait_bytes($urandom_range(0, 4));
      repeat ($urandom_range(0, 40)) @(negedge clk);
      sel = $urandom_range(0, 7);
      ev(combos[sel][3], combos[sel][2], combos[sel][1], combos[sel][0]);
    end
    wait_bytes(3); rnd_ready = 0;

    // pause on byte boundary
    wait_bytes(3);
    @(negedge clk); ready_fix = 0;
    repeat (8 * H + 6) @(negedge clk);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (50) begin
      @(negedge clk);
      cnt_a += o_byte_en; cnt_b += o_sclk; cnt_c += o_nss;
    end
    chk("pause_byte_en", cnt_a, 0);
    chk("pause_sclk", cnt_b, 0);
    chk("pause_nss", cnt_c, 0);
    ready_fix = 1; wait_bytes(6);

    // interrupt during DATA
    wait_bytes(2);
    @(negedge clk); i_interrupt = 1;
    @(negedge clk); i_interrupt = 0;
    c = 0;
    while (!o_nss && c < 2 * H) begin @(negedge clk); c++; end
    chk("int_nss_high", o_nss, 1);
    cnt_a = 0; cnt_b = 0;
    repeat (150) begin
      @(negedge clk);
      cnt_a += o_byte_en; cnt_b += !o_nss;
    end
    chk("int_no_bytes", cnt_a, 0);
    chk("int_wait_idle", cnt_b, 0);

    ev(0, 0, 1, 0); wait_bytes(4);
    chk("flush_addr", rd_addr, exp_start());

    // next+back together in WAIT does nothing
    ev(0, 0, 0, 1);
    repeat (10) @(negedge clk);
    ev(1, 1, 0, 0);
    cnt_a = 0;
    repeat (100) begin @(negedge clk); cnt_a += !o_nss; end
    chk("nav_cancel_idle", cnt_a, 0);

    // reset mid-ADDR
    ev(1, 0, 0, 0);
    c = 0;
    while (!(!o_nss && rises == 16) && c < 2000) begin @(negedge clk); c++; end
    chk("reached_addr_phase", rises, 16);
    rst_n = 0; exp_idx = 0;
    @(negedge clk);
    chk("midrst_nss", o_nss, 1);
    chk("midrst_sclk", o_sclk, 0);
    chk("midrst_oe", o_mosi_oe, 0);
    chk("midrst_byte_en", o_byte_en, 0);
    rst_n = 1;
    wait_bytes(4);
    chk("post_rst_addr", rd_addr, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
